// File: rtl/jtkcpu_stkseq_if.sv
// Stack sequencer bus: start requests from the control unit, register-file
// controls and memory strobes. The control side is the master.
interface jtkcpu_stkseq_if;
   logic       cen;
   logic       psh_start;
   logic       pul_start;
   logic       rti;
   logic [7:0] mask;
   logic       ussel;
   logic [7:0] mem_din;
   logic       mem_ok;
   logic       busy;
   logic       done;
   logic [7:0] psh_sel;
   logic       psh_hilon;
   logic       psh_ussel;
   logic       pshdec;
   logic       pul_en;
   logic       mem_wr;
   logic       mem_rd;

   modport master (
      output cen, psh_start, pul_start, rti, mask, ussel, mem_din, mem_ok,
      input  busy, done, psh_sel, psh_hilon, psh_ussel, pshdec, pul_en,
             mem_wr, mem_rd
   );

   modport slave (
      input  cen, psh_start, pul_start, rti, mask, ussel, mem_din, mem_ok,
      output busy, done, psh_sel, psh_hilon, psh_ussel, pshdec, pul_en,
             mem_wr, mem_rd
   );
endinterface

// File: rtl/jtkcpu_stkseq.sv
// Push/pull sequencer for PSHS/PSHU/PULS/PULU, interrupt entry and RTI.
// Walks the register mask one byte per bus access. Pushes go PC down to CC,
// 16-bit registers low byte first; pulls go CC up to PC, high byte first.
// In RTI mode only CC is pulled first; its E bit then decides whether the
// whole frame or just PC follows.
module jtkcpu_stkseq #(
   parameter int CCE_BIT = 7
) (
   input logic            clk,
   input logic            rst,
   jtkcpu_stkseq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PSH_DEC = 3'd1,
      PSH_WR  = 3'd2,
      PUL_RD  = 3'd3,
      PUL_LD  = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t     state_r;
   logic [7:0] mask_r, sel_r, din_r;
   logic       rti_r, hilon_r, ussel_r;
   logic       busy_r, done_r, pshdec_r, pul_en_r, mem_wr_r, mem_rd_r;

   logic [7:0] rem_s, psh_nxt_s, pul_nxt_s, start_psh_s, start_pul_s;
   logic [7:0] rti_mask_s, rti_first_s;

   // Highest set bit of m as a one-hot vector (push order)
   function automatic logic [7:0] pick_hi(input logic [7:0] m);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++)
         if (m[i]) r = 8'h01 << i;
      return r;
   endfunction

   // Lowest set bit of m as a one-hot vector (pull order)
   function automatic logic [7:0] pick_lo(input logic [7:0] m);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = 8'h01 << i;
      return r;
   endfunction

   // X, Y, U/S and PC are the 16-bit registers
   function automatic logic is16(input logic [7:0] s);
      return |s[7:4];
   endfunction

   // Next-register candidates derived from the remaining mask
   always_comb begin
      rem_s       = mask_r & ~sel_r;
      psh_nxt_s   = pick_hi(rem_s);
      pul_nxt_s   = pick_lo(rem_s);
      start_psh_s = pick_hi(bus.mask);
      start_pul_s = pick_lo(bus.mask);
      rti_mask_s  = din_r[CCE_BIT] ? 8'hFE : 8'h80;
      rti_first_s = pick_lo(rti_mask_s);
   end

   // Sequencer FSM with registered outputs; advances only on cen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         mask_r   <= 8'h00;
         sel_r    <= 8'h00;
         din_r    <= 8'h00;
         rti_r    <= 1'b0;
         hilon_r  <= 1'b0;
         ussel_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         pshdec_r <= 1'b0;
         pul_en_r <= 1'b0;
         mem_wr_r <= 1'b0;
         mem_rd_r <= 1'b0;
      end else if (bus.cen) begin
         case (state_r)
            IDLE: begin
               if (bus.psh_start) begin
                  mask_r  <= bus.mask;
                  ussel_r <= bus.ussel;
                  rti_r   <= 1'b0;
                  hilon_r <= 1'b0;
                  if (bus.mask == 8'h00) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                     sel_r   <= 8'h00;
                  end else begin
                     state_r  <= PSH_DEC;
                     busy_r   <= 1'b1;
                     pshdec_r <= 1'b1;
                     sel_r    <= start_psh_s;
                  end
               end else if (bus.pul_start) begin
                  ussel_r <= bus.ussel;
                  if (bus.rti) begin
                     mask_r   <= 8'h01;
                     rti_r    <= 1'b1;
                     sel_r    <= 8'h01;
                     hilon_r  <= 1'b0;
                     state_r  <= PUL_RD;
                     busy_r   <= 1'b1;
                     mem_rd_r <= 1'b1;
                  end else if (bus.mask == 8'h00) begin
                     mask_r  <= 8'h00;
                     rti_r   <= 1'b0;
                     sel_r   <= 8'h00;
                     hilon_r <= 1'b0;
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end else begin
                     mask_r   <= bus.mask;
                     rti_r    <= 1'b0;
                     sel_r    <= start_pul_s;
                     hilon_r  <= is16(start_pul_s);
                     state_r  <= PUL_RD;
                     busy_r   <= 1'b1;
                     mem_rd_r <= 1'b1;
                  end
               end
            end
            PSH_DEC: begin
               pshdec_r <= 1'b0;
               mem_wr_r <= 1'b1;
               state_r  <= PSH_WR;
            end
            PSH_WR: begin
               if (bus.mem_ok) begin
                  mem_wr_r <= 1'b0;
                  if (is16(sel_r) && !hilon_r) begin
                     hilon_r  <= 1'b1;
                     pshdec_r <= 1'b1;
                     state_r  <= PSH_DEC;
                  end else begin
                     mask_r <= rem_s;
                     if (rem_s == 8'h00) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        sel_r   <= 8'h00;
                        hilon_r <= 1'b0;
                     end else begin
                        sel_r    <= psh_nxt_s;
                        hilon_r  <= 1'b0;
                        pshdec_r <= 1'b1;
                        state_r  <= PSH_DEC;
                     end
                  end
               end
            end
            PUL_RD: begin
               if (bus.mem_ok) begin
                  mem_rd_r <= 1'b0;
                  din_r    <= bus.mem_din;
                  pul_en_r <= 1'b1;
                  state_r  <= PUL_LD;
               end
            end
            PUL_LD: begin
               pul_en_r <= 1'b0;
               if (rti_r) begin
                  // CC just pulled: E bit selects full frame or PC only
                  rti_r    <= 1'b0;
                  mask_r   <= rti_mask_s;
                  sel_r    <= rti_first_s;
                  hilon_r  <= is16(rti_first_s);
                  mem_rd_r <= 1'b1;
                  state_r  <= PUL_RD;
               end else if (is16(sel_r) && hilon_r) begin
                  hilon_r  <= 1'b0;
                  mem_rd_r <= 1'b1;
                  state_r  <= PUL_RD;
               end else begin
                  mask_r <= rem_s;
                  if (rem_s == 8'h00) begin
                     state_r <= DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     sel_r   <= 8'h00;
                     hilon_r <= 1'b0;
                  end else begin
                     sel_r    <= pul_nxt_s;
                     hilon_r  <= is16(pul_nxt_s);
                     mem_rd_r <= 1'b1;
                     state_r  <= PUL_RD;
                  end
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r  <= IDLE;
               busy_r   <= 1'b0;
               done_r   <= 1'b0;
               pshdec_r <= 1'b0;
               pul_en_r <= 1'b0;
               mem_wr_r <= 1'b0;
               mem_rd_r <= 1'b0;
               sel_r    <= 8'h00;
               hilon_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.psh_sel   = sel_r;
   assign bus.psh_hilon = hilon_r;
   assign bus.psh_ussel = ussel_r;
   assign bus.pshdec    = pshdec_r;
   assign bus.pul_en    = pul_en_r;
   assign bus.mem_wr    = mem_wr_r;
   assign bus.mem_rd    = mem_rd_r;

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Scoreboard bench for jtkcpu_stkseq: expected pshdec/pul_en/done events are
// queued when a sequence is started; a monitor pops them as the DUT pulses.
module tb_jtkcpu_stkseq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtkcpu_stkseq_if bus ();

   jtkcpu_stkseq #(.CCE_BIT(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // record: kind(2) sel(8) hilon(1) ussel(1); kind 0=pshdec 1=pul_en 2=done
   typedef logic [11:0] rec_t;
   rec_t exp_q[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   bus_cnt = 0;

   function automatic rec_t mk(input logic [1:0] k, input logic [7:0] s,
                               input logic h, input logic u);
      return {k, s, h, u};
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic pop_chk(input logic [1:0] k, input string name);
      rec_t act;
      act = mk(k, bus.psh_sel, bus.psh_hilon, bus.psh_ussel);
      if (exp_q.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_%s: got %h expected none", name, act);
      end else begin
         cmp(name, act, exp_q.pop_front());
      end
   endtask

   // Monitor: each pulse counted once, on the cen cycle that consumes it
   always @(negedge clk) begin
      if (!rst && bus.cen === 1'b1) begin
         if (bus.mem_ok && (bus.mem_wr || bus.mem_rd)) bus_cnt++;
         if (bus.pshdec) pop_chk(2'd0, "pshdec");
         if (bus.pul_en) pop_chk(2'd1, "pul_en");
         if (bus.done)   pop_chk(2'd2, "done");
      end
   end

   task automatic run_seq(input logic psh, input logic pul, input logic r,
                          input logic [7:0] m, input logic us, input bit tog,
                          output int cyc);
      bus.cen = 1'b1;
      bus_cnt = 0;
      bus.psh_start = psh;
      bus.pul_start = pul;
      bus.rti = r;
      bus.mask = m;
      bus.ussel = us;
      @(posedge clk); #1;
      bus.psh_start = 1'b0;
      bus.pul_start = 1'b0;
      bus.rti = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 200) begin
         if (tog) bus.cen = ~bus.cen;
         @(posedge clk); #1;
         cyc++;
      end
      if (bus.done !== 1'b1) cmp("done_timeout", 32'd0, 32'd1);
      bus.cen = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   int cyc;

   initial begin
      bus.cen = 1'b1;
      bus.psh_start = 1'b0;
      bus.pul_start = 1'b0;
      bus.rti = 1'b0;
      bus.mask = 8'h00;
      bus.ussel = 1'b0;
      bus.mem_din = 8'h00;
      bus.mem_ok = 1'b1;

      #12;
      cmp("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
      cmp("rst_sel", {24'd0, bus.psh_sel}, 32'd0);
      cmp("rst_strobes", {26'd0, bus.pshdec, bus.pul_en, bus.mem_wr, bus.mem_rd,
                          bus.psh_hilon, bus.psh_ussel}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // PSHS mask 81: PC lo, PC hi, CC
      exp_q.push_back(mk(2'd0, 8'h80, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd0, 8'h80, 1'b1, 1'b0));
      exp_q.push_back(mk(2'd0, 8'h01, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b0));
      run_seq(1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, cyc);
      cmp("pshs_done_cycle", cyc, 32'd7);
      cmp("pshs_bytes", bus_cnt, 32'd3);

      // PULU mask 12: A, X hi, X lo
      bus.mem_din = 8'h55;
      exp_q.push_back(mk(2'd1, 8'h02, 1'b0, 1'b1));
      exp_q.push_back(mk(2'd1, 8'h10, 1'b1, 1'b1));
      exp_q.push_back(mk(2'd1, 8'h10, 1'b0, 1'b1));
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b1));
      run_seq(1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, cyc);
      cmp("pulu_bytes", bus_cnt, 32'd3);

      // RTI with E=1: CC, A, B, DP, X, Y, U, PC
      bus.mem_din = 8'h80;
      exp_q.push_back(mk(2'd1, 8'h01, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h02, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h04, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h08, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h10, 1'b1, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h10, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h20, 1'b1, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h20, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h40, 1'b1, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h40, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h80, 1'b1, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h80, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b0));
      run_seq(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, cyc);
      cmp("rti_full_bytes", bus_cnt, 32'd12);

      // RTI with E=0: CC, PC hi, PC lo
      bus.mem_din = 8'h00;
      exp_q.push_back(mk(2'd1, 8'h01, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h80, 1'b1, 1'b0));
      exp_q.push_back(mk(2'd1, 8'h80, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b0));
      run_seq(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, cyc);
      cmp("rti_pc_bytes", bus_cnt, 32'd3);

      // Empty mask: done right after start, no bus traffic
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b0));
      run_seq(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cyc);
      cmp("mask0_done_cycle", cyc, 32'd1);
      cmp("mask0_bytes", bus_cnt, 32'd0);

      // Push and pull together: push wins
      exp_q.push_back(mk(2'd0, 8'h02, 1'b0, 1'b1));
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b1));
      run_seq(1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, cyc);
      cmp("prio_bytes", bus_cnt, 32'd1);

      // cen toggling: stretched pulses must count once
      exp_q.push_back(mk(2'd0, 8'h08, 1'b0, 1'b0));
      exp_q.push_back(mk(2'd2, 8'h00, 1'b0, 1'b0));
      run_seq(1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1, cyc);
      cmp("cen_bytes", bus_cnt, 32'd1);

      // Reset while a write is pending
      bus.mem_ok = 1'b0;
      exp_q.push_back(mk(2'd0, 8'h80, 1'b0, 1'b0));
      bus.psh_start = 1'b1;
      bus.mask = 8'h80;
      @(posedge clk); #1;
      bus.psh_start = 1'b0;
      for (int i = 0; i < 10 && bus.mem_wr !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      cmp("rstwr_mem_wr_seen", {31'd0, bus.mem_wr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      cmp("rstwr_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cmp("rstwr_busy", {31'd0, bus.busy}, 32'd0);
      cmp("rstwr_sel", {24'd0, bus.psh_sel}, 32'd0);
      @(negedge clk) rst = 1'b0;
      bus.mem_ok = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      cmp("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
